// File: rtl/uart_tx_queue_if.sv
// Host/serializer-facing signal bundle for uart_tx_queue.
// The slave view belongs to the queue; the master view belongs to whatever drives it.
interface uart_tx_queue_if #(
  parameter int unsigned AW = 4
) ();

  logic          push;
  logic [7:0]    push_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          uart_tx_ready;
  logic          uart_write_enable;
  logic [7:0]    uart_tx_data;

  modport master (
    output push,
    output push_data,
    output flush,
    output uart_tx_ready,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  uart_write_enable,
    input  uart_tx_data
  );

  modport slave (
    input  push,
    input  push_data,
    input  flush,
    input  uart_tx_ready,
    output full,
    output empty,
    output count,
    output overflow,
    output uart_write_enable,
    output uart_tx_data
  );

endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART serializer through an IDLE/OFFER/BUSY handshake.
// Bytes are popped into a holding register when the serializer is idle, then offered
// with write_enable until the serializer reports busy, then held off until it is idle again.
module uart_tx_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  uart_tx_queue_if.slave    bus_io
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOffer = 2'd1,
    StBusy  = 2'd2
  } state_e;

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_data_q, tx_data_d;
  state_e        state_q, state_d;

  logic full, empty, push_ok, push_drop, pop;

  // Status flags come from the pre-edge count only.
  always_comb begin
    full      = (count_q == FullCount);
    empty     = (count_q == '0);
    // Flush wins over a simultaneous push and does not flag it as an overflow.
    push_ok   = bus_io.push && !full && !bus_io.flush;
    push_drop = bus_io.push && full && !bus_io.flush;
    // A flush in IDLE discards the head byte instead of starting a new handshake.
    pop       = (state_q == StIdle) && !empty && bus_io.uart_tx_ready && !bus_io.flush;
  end

  // Handshake FSM: unused code 3 falls back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StOffer;
      StOffer: if (!bus_io.uart_tx_ready) state_d = StBusy;
      StBusy:  if (bus_io.uart_tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pointer, count, overflow and holding-register next state.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (bus_io.flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (push_drop) overflow_d = 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset so it has none.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus_io.push_data;
  end

  // Control state with synchronous reset taking priority over everything.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // write_enable is decoded straight from the state register, so it is glitch-free.
  always_comb begin
    bus_io.full              = full;
    bus_io.empty             = empty;
    bus_io.count             = count_q;
    bus_io.overflow          = overflow_q;
    bus_io.uart_write_enable = (state_q == StOffer);
    bus_io.uart_tx_data      = tx_data_q;
  end

endmodule
